// File: rtl/md_pkg.sv
//------------------------------------------------------------------------------
// md_pkg
// Shared operation and FSM state encodings for the iterative multiply/divide unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
//------------------------------------------------------------------------------
// muldiv_unit_if
// Execute-stage controller <-> multiply/divide unit handshake and HI/LO bus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface muldiv_unit_if
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

`default_nettype wire

// File: rtl/cond_neg.sv
//------------------------------------------------------------------------------
// cond_neg
// Conditional two's-complement: passes x through, or negates it when neg is set.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cond_neg #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] x_i,
    input  wire logic             neg_i,
    output logic      [WIDTH-1:0] y_o
);

    assign y_o = neg_i ? ('0 - x_i) : x_i;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// muldiv_unit
// Iterative shift-add multiplier / restoring divider with architectural HI/LO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    muldiv_unit_if.slave    bus
);

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               signed_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               signed_q;
    logic               div_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign signed_in = md_is_signed(bus.op);
    assign signed_q  = md_is_signed(op_q);
    assign div_q     = md_is_div(op_q);

    cond_neg #(.WIDTH(WIDTH)) u_neg_a (
        .x_i   (bus.a),
        .neg_i (signed_in & bus.a[WIDTH-1]),
        .y_o   (mag_a)
    );

    cond_neg #(.WIDTH(WIDTH)) u_neg_b (
        .x_i   (bus.b),
        .neg_i (signed_in & bus.b[WIDTH-1]),
        .y_o   (mag_b)
    );

    cond_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
        .x_i   (acc_q),
        .neg_i (signed_q & (sign_a_q ^ sign_b_q)),
        .y_o   (prod_fixed)
    );

    cond_neg #(.WIDTH(WIDTH)) u_neg_quo (
        .x_i   (acc_q[WIDTH-1:0]),
        .neg_i (signed_q & (sign_a_q ^ sign_b_q)),
        .y_o   (quo_fixed)
    );

    cond_neg #(.WIDTH(WIDTH)) u_neg_rem (
        .x_i   (rem_q[WIDTH-1:0]),
        .neg_i (signed_q & sign_a_q),
        .y_o   (rem_fixed)
    );

    // Multiply: low half of acc holds the multiplier being shifted out.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    // Divide: low half of acc shifts dividend bits out and quotient bits in.
    assign div_trial = {rem_q, acc_q[WIDTH-1]} - {2'b00, opnd_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= MD_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = CALC;
                    op_d     = bus.op;
                    sign_a_d = signed_in & bus.a[WIDTH-1];
                    sign_b_d = signed_in & bus.b[WIDTH-1];
                    b_zero_d = (bus.b == '0);
                    a_raw_d  = bus.a;
                    cnt_d    = '0;
                    rem_d    = '0;
                    dbz_d    = 1'b0;
                    if (md_is_div(bus.op)) begin
                        opnd_d = mag_b;
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                    end
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end

            CALC: begin
                if (div_q) begin
                    acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
                    rem_d = div_trial[WIDTH+1] ? {rem_q[WIDTH-1:0], acc_q[WIDTH-1]}
                                               : div_trial[WIDTH:0];
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = FIX;
            end

            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    if (b_zero_q) begin
                        lo_d  = '1;
                        hi_d  = a_raw_q;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = quo_fixed;
                        hi_d = rem_fixed;
                    end
                end else begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// tb_muldiv_unit
// Vector table, directed corner sequences and random ops against a reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        md_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz);
        longint      sa, sb, q, r, p;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        case (op)
            MD_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            MD_MULT: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    lo  = 32'hFFFF_FFFF;
                    hi  = a;
                    dbz = 1'b1;
                end else if (op == MD_DIVU) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
        endcase
    endfunction

    task automatic drive_start(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts edges after the launch edge until done is seen; flags any early hi/lo change.
    task automatic wait_done(input int n0, output int n, output logic early);
        logic [31:0] hi0, lo0;
        hi0   = bus.hi;
        lo0   = bus.lo;
        early = 1'b0;
        n     = n0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) break;
            if (bus.hi !== hi0 || bus.lo !== lo0) early = 1'b1;
        end
    endtask

    task automatic finish_checks(input string name, input int n, input logic early,
                                 input logic [31:0] ehi, input logic [31:0] elo,
                                 input logic edbz);
        chk({name, " latency"}, 32'(n), 32'd33);
        chk({name, " hold"}, 32'(early), 32'd0);
        chk({name, " hi"}, bus.hi, ehi);
        chk({name, " lo"}, bus.lo, elo);
        chk({name, " dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        @(negedge clk);
        chk({name, " done pulse"}, 32'(bus.done), 32'd0);
        chk({name, " busy idle"}, 32'(bus.busy), 32'd0);
        chk({name, " dbz sticky"}, 32'(bus.div_by_zero), 32'(edbz));
    endtask

    task automatic do_op(input string name, input md_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edbz);
        int   n;
        logic early;
        drive_start(op, a, b);
        chk({name, " busy"}, 32'(bus.busy), 32'd1);
        chk({name, " dbz clr"}, 32'(bus.div_by_zero), 32'd0);
        wait_done(0, n, early);
        finish_checks(name, n, early, ehi, elo, edbz);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        int          n;
        logic        early;
        logic [31:0] mhi, mlo;
        logic        mdbz;
        md_op_e      rop;
        logic [31:0] ra, rb;

        vecs[0] = '{"multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{"mult -3*5", MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{"div -7/2",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{"divu 10/0", MD_DIVU,  32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
        vecs[4] = '{"div min/-1",MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5] = '{"divu 100/7",MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[6] = '{"div 7/-2",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[7] = '{"mult min2", MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8] = '{"div -7/0",  MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9] = '{"multu 6*7", MD_MULTU, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset dbz", 32'(bus.div_by_zero), 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // mthi / mtlo in IDLE
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        chk("mthi hi", bus.hi, 32'h0000_1234);
        chk("mthi lo untouched", bus.lo, 32'd0);
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_5678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo lo", bus.lo, 32'h0000_5678);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mthi+mtlo hi", bus.hi, 32'h0BAD_F00D);
        chk("mthi+mtlo lo", bus.lo, 32'h0BAD_F00D);

        // start and mtlo in the same IDLE cycle: the write is dropped
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_0077;
        drive_start(MD_MULTU, 32'd2, 32'd3);
        bus.lo_we = 1'b0;
        chk("start+mtlo dropped", bus.lo, 32'h0BAD_F00D);
        wait_done(0, n, early);
        finish_checks("start+mtlo", n, early, 32'd0, 32'd6, 1'b0);

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);

        // mthi/mtlo while busy are ignored
        drive_start(MD_DIVU, 32'd1000, 32'd33);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("busy write hi", bus.hi, 32'd0);
        chk("busy write lo", bus.lo, 32'd42);
        wait_done(1, n, early);
        finish_checks("busy write", n, early, 32'd10, 32'd30, 1'b0);

        // start while busy is ignored
        drive_start(MD_MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        drive_start(MD_DIVU, 32'd100, 32'd3);
        wait_done(5, n, early);
        finish_checks("start ignored", n, early, 32'd0, 32'd42, 1'b0);

        // back-to-back: new start accepted in the done cycle
        drive_start(MD_MULT, 32'hFFFF_FFFF, 32'd9);
        wait_done(0, n, early);
        chk("b2b first lo", bus.lo, 32'hFFFF_FFF7);
        chk("b2b first hi", bus.hi, 32'hFFFF_FFFF);
        drive_start(MD_DIVU, 32'd50, 32'd7);
        chk("b2b second busy", 32'(bus.busy), 32'd1);
        wait_done(0, n, early);
        finish_checks("b2b second", n, early, 32'd1, 32'd7, 1'b0);

        // asynchronous reset in the middle of an operation
        drive_start(MD_MULT, 32'd123456, 32'd789);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        chk("midreset hi", bus.hi, 32'd0);
        chk("midreset lo", bus.lo, 32'd0);
        chk("midreset dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("post-reset multu", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        // randomized operations against the reference model
        for (int k = 0; k < 150; k++) begin
            rop = md_op_e'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = $urandom_range(1, 16);
                default: ;
            endcase
            model(rop, ra, rb, mhi, mlo, mdbz);
            do_op($sformatf("rand%0d op%0d", k, rop), rop, ra, rb, mhi, mlo, mdbz);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, sitting beside the single-cycle ALU in the execute stage. It executes mult, multu, div and divu over a parametrised operand width and holds results in architectural HI/LO registers. It exposes a start/busy/done handshake so the controller can stall on multi-cycle operations. It also services mthi/mtlo writes.

## Interface
- WIDTH, 32, operand width in bits (≥ 2); HI and LO are each WIDTH bits.
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  operation select: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  mthi: write wdata into HI.
- lo_we  in  1  mtlo: write wdata into LO.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO are valid for the completed operation.
- div_by_zero  out  1  sticky until next start; set when a div/divu completes with b == 0.
- hi  out  WIDTH  HI register (mfhi).
- lo  out  WIDTH  LO register (mflo).

## Operation
- The FSM has three states: IDLE, CALC and FIX.
- **Launch (IDLE → CALC):** start=1 in IDLE captures op, the sign flags of a and b, and the magnitudes |a| and |b|.
  - Magnitudes apply to signed ops only; unsigned ops use raw values.
  - The iteration counter is cleared and div_by_zero is cleared.
- **CALC:** one iteration per edge, WIDTH iterations, then → FIX.
  - Multiply: shift-add on a 2·WIDTH accumulator, one multiplier bit per iteration.
  - Divide: restoring divide, one quotient bit per iteration; remainder register is WIDTH+1 bits.
- **FIX:** sign correction.
  - Product is negated (2·WIDTH-bit two's complement) if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - HI ← product[2W-1:W] or remainder; LO ← product[W-1:0] or quotient.
  - done=1 for the following cycle; state → IDLE.
- **Divide by zero:** iterations run normally (fixed latency).
  - Final result is forced to LO = all ones, HI = a (original value).
  - div_by_zero=1 is asserted with done.
- **Most-negative ÷ −1 (signed):** LO = 100…0 (wraps), HI = 0; no flag.
- **mthi/mtlo:** hi_we/lo_we write in IDLE only; both may be asserted together.
  - Ignored while busy.
  - If start and a write occur in the same IDLE cycle, start wins and the write is dropped.
- **start while busy:** ignored; there is no queueing.
- **Reset, including mid-operation:** state IDLE; hi, lo, counter and accumulators = 0; busy=0, done=0, div_by_zero=0.

## Timing
- Edge E0 samples start. busy=1 from after E0 until after edge E0+WIDTH+1.
- busy is decoded as state ≠ IDLE.
- HI/LO update at edge E0+WIDTH+1. done is high exactly in the cycle after that edge, in IDLE.
- Total latency is WIDTH+1 edges, independent of operand values (33 for WIDTH=32).
- A new start is accepted in the done cycle, giving back-to-back operations.
- hi/lo outputs change only at E0+WIDTH+1, on an mthi/mtlo edge, or at reset.
- Intermediate accumulators are never visible on hi/lo.
- The counter is $clog2(WIDTH+1) bits wide and wraps only via state transition.

## Structure
- Shared package md_pkg holds:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - FSM state encoding IDLE/CALC/FIX.
- One sub-module: cond_neg, a parametrised conditional two's-complement (width parameter, neg input).
  - Used for operand magnitude at launch.
  - Used for quotient/remainder/product correction in FIX.
- The FSM, datapath and HI/LO registers live in muldiv_unit.

## Test plan
All scenarios use WIDTH=32.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 edges, hi=0xFFFFFFFE, lo=0x00000001, done pulse of 1 cycle.
- mult a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=10, b=0 → lo=0xFFFFFFFF, hi=0x0000000A, div_by_zero=1; div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- start pulsed again at E0+5 with different operands → ignored, original result delivered at E0+33; start in the done cycle → accepted, next done at +33.
- mthi wdata=0x1234 in IDLE → hi=0x1234 next edge; mtlo during busy → lo unchanged; start+mtlo same cycle → write dropped.
- reset asserted asynchronously at iteration 10 → busy, done, hi, lo = 0 immediately; a fresh multu 6×7 then gives lo=42, hi=0.
